deserializer: RTL and testbench
===============================

# deserializer

Receive-side counterpart of `serializer`: watches a single-bit serial line (the `txd` output of `serializer`, looped to `rxd`) and rebuilds parallel words. It detects a start bit, samples WIDTH data bits LSB first at mid-bit, and checks the stop bit. A good frame produces a one-cycle `valid` strobe with the word; a bad stop bit produces a one-cycle `frame_err` strobe. It sits directly downstream of `serializer` and replaces the bench-only line checker in loopback tests.

## Interface
- WIDTH, 8, data bits per frame (≥1)
- CLKS_PER_BIT, 1, clock cycles per bit cell (≥1); HALF = (CLKS_PER_BIT-1)/2, integer division
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- rxd  input  1  serial line; idle high; same clock domain as `clk`, no synchronizer
- data  output  WIDTH  last correctly received word; holds until the next good frame
- valid  output  1  one-cycle strobe: `data` updated this cycle
- frame_err  output  1  one-cycle strobe: stop bit sampled low
- busy  output  1  high while a frame is in progress

## Operation
- Frame format: start bit (0), then WIDTH data bits LSB first, then one stop bit (1).
- States:
  - IDLE
  - START: verify the start bit.
  - DATA: shift in bits; counter 0..WIDTH-1.
  - STOP
  - BREAK: wait for the line to go idle.
- Bit-cell counter: 0..CLKS_PER_BIT-1. Data-bit counter: 0..WIDTH-1.
- Frame origin t0: the first cycle `rxd`=0 is sampled in IDLE. Bit i (0 = start, 1..WIDTH = data, WIDTH+1 = stop) is sampled at cycle t0 + i·CLKS_PER_BIT + HALF.
- Start sample = 1: false start. Return to IDLE; no strobe; `data` unchanged.
- Data bit j is sampled at bit index j+1. It is shifted into a shift register separate from `data`.
- Stop sample = 1:
  - Next cycle: `data` ← shift register, `valid`=1.
  - State returns to IDLE, so a start can be detected in that same cycle.
- Stop sample = 0:
  - Next cycle: `frame_err`=1; `data` unchanged.
  - State → BREAK. Leave BREAK for IDLE on the first cycle `rxd`=1 is sampled.
- `valid` and `frame_err` are never high together.
- `busy` = (state ≠ IDLE), registered.
- Reset values: `data`=0, `valid`=0, `frame_err`=0, `busy`=0; state IDLE; counters 0; shift register 0.
- Reset mid-frame: the partial word is discarded, no strobe is issued, and outputs go to reset values on the next edge.
- `rst` has priority over every event in the same cycle.

## Timing
- Start-bit check for CLKS_PER_BIT=1: HALF=0, so the start bit is verified at t0 itself. A low seen in IDLE counts as a valid start.
- Cycle counts for CLKS_PER_BIT=1, WIDTH=8:
  - Data bit j sampled at t0+1+j.
  - Stop sampled at t0+9.
  - `valid` at t0+10.
  - `busy` high t0+1..t0+9.
- General latency: the strobe fires at t0 + (WIDTH+1)·CLKS_PER_BIT + HALF + 1.
- Back-to-back frames:
  - The next start may begin in the cycle right after the stop sample.
  - Stop cells shortened to HALF+1 cycles are accepted.
  - No idle gap is required between frames.
- In IDLE, `rxd` is evaluated every cycle. No start is detected in the cycle a strobe is issued unless `rxd`=0 in that cycle, in which case that cycle is t0.
- Data-bit counter wrap: after bit WIDTH-1 is sampled, the next sample is the stop bit. Exactly WIDTH bits are shifted in.

## Test plan
- Single frame, WIDTH=8, CLKS_PER_BIT=1: send 0xA5 (line 0,1,0,1,0,0,1,0,1,1) from t0 → `valid`=1 at t0+10 only, `data`=0xA5, `busy` high t0+1..t0+9.
- Back-to-back frames 0x3C then 0xC3, no idle between them, CLKS_PER_BIT=1 → two `valid` pulses 10 cycles apart, carrying 0x3C then 0xC3; `frame_err` never asserted.
- Glitch start, CLKS_PER_BIT=4: `rxd` low for 1 cycle, then high → state back to IDLE at t0+1 (HALF=1), no strobe, `data` keeps its previous value.
- Framing error: 0x5A frame with stop bit 0 and the line held low 5 more cycles → `frame_err` one cycle, `data` unchanged, `busy` stays high until `rxd` returns high, then the next 0x11 frame is received correctly.
- Reset mid-frame: assert `rst` for 1 cycle after data bit 3, then send a full 0xFF frame → no strobe for the aborted frame, all outputs 0 after reset, `valid` with `data`=0xFF for the new frame.
- Loopback with `serializer` (WIDTH=8): send 0x00, 0x01, 0x80, 0xFF → each word appears once on `data` with `valid`, in order.

Source files
------------

// File: rtl/deserializer.sv
// Serial-to-parallel receiver: start bit, WIDTH data bits LSB first, one stop bit,
// sampled mid-bit. Good frames strobe valid with the word; bad stop bits strobe frame_err.
module deserializer #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rxd,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             frame_err,
    output logic             busy
);
    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CELL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'((HALF > 0) ? HALF - 1 : 0);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
    localparam bit            HALF_ZERO = (HALF == 0);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shift_q, shift_d, shift_in;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             busy_q, busy_d;

    // New bits enter at the top so that after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_shift_one
            assign shift_in = rxd;
        end else begin : g_shift_many
            assign shift_in = {rxd, shift_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    // cnt_q counts cycles since the previous sample point; the next sample is due
    // when it reaches the end of the current interval.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rxd) begin
                    // With HALF=0 the detecting cycle is also the start-bit sample.
                    state_d = HALF_ZERO ? S_DATA : S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rxd ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == CELL_LAST) begin
                    cnt_d   = '0;
                    shift_d = shift_in;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == CELL_LAST) begin
                    cnt_d = '0;
                    if (rxd) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_BREAK: begin
                if (rxd) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: one instance at 1 clock/bit, one at 4 clocks/bit.
`timescale 1ns/1ps
module tb_deserializer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd1 = 1'b1, rxd4 = 1'b1;
    logic [7:0] data1, data4;
    logic       valid1, valid4, ferr1, ferr4, busy1, busy4;

    int n_cmp = 0;
    int n_bad = 0;

    bit         line_q[$];
    logic       ov[0:127], ob[0:127], oe[0:127];
    logic [7:0] od[0:127];

    always #5 clk = ~clk;

    deserializer #(.WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .rxd(rxd1), .data(data1),
        .valid(valid1), .frame_err(ferr1), .busy(busy1)
    );
    deserializer #(.WIDTH(8), .CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst(rst), .rxd(rxd4), .data(data4),
        .valid(valid4), .frame_err(ferr4), .busy(busy4)
    );

    task automatic add_const(input bit b, input int n);
        for (int i = 0; i < n; i++) line_q.push_back(b);
    endtask

    task automatic add_frame(input logic [7:0] w, input bit stop, input int cpb, input int stop_cells);
        add_const(1'b0, cpb);
        for (int i = 0; i < 8; i++) add_const(w[i], cpb);
        add_const(stop, stop_cells);
    endtask

    // Iteration k observes outputs for cycle t0+k, then drives the line bit sampled at edge t0+k.
    task automatic play(input int sel, input int ncyc, input int rst_at);
        bit b;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (sel == 1) begin
                ov[k] = valid1; od[k] = data1; ob[k] = busy1; oe[k] = ferr1;
            end else begin
                ov[k] = valid4; od[k] = data4; ob[k] = busy4; oe[k] = ferr4;
            end
            rst = (k == rst_at);
            b = (k < line_q.size()) ? line_q[k] : 1'b1;
            if (sel == 1) rxd1 = b; else rxd4 = b;
        end
        line_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if ({data1, valid1, ferr1, busy1} !== 11'd0) begin
            n_bad++; $display("FAIL reset_dut1 got data=%h v=%b fe=%b busy=%b want all 0", data1, valid1, ferr1, busy1);
        end
        n_cmp++; if ({data4, valid4, ferr4, busy4} !== 11'd0) begin
            n_bad++; $display("FAIL reset_dut4 got data=%h v=%b fe=%b busy=%b want all 0", data4, valid4, ferr4, busy4);
        end
        $display("reset: outputs checked");
    endtask

    task automatic test_single();
        add_frame(8'hA5, 1'b1, 1, 1);
        play(1, 14, -1);
        for (int k = 0; k < 14; k++) begin
            n_cmp++; if (ov[k] !== (k == 10)) begin
                n_bad++; $display("FAIL single_valid k=%0d got %b want %b", k, ov[k], (k == 10));
            end
            n_cmp++; if (ob[k] !== (k >= 1 && k <= 9)) begin
                n_bad++; $display("FAIL single_busy k=%0d got %b want %b", k, ob[k], (k >= 1 && k <= 9));
            end
        end
        n_cmp++; if (od[10] !== 8'hA5) begin
            n_bad++; $display("FAIL single_data got %h want a5", od[10]);
        end
        n_cmp++; if (od[13] !== 8'hA5) begin
            n_bad++; $display("FAIL single_hold got %h want a5", od[13]);
        end
        $display("single: sent a5, data@10=%h", od[10]);
    endtask

    task automatic test_back_to_back();
        add_frame(8'h3C, 1'b1, 1, 1);
        add_frame(8'hC3, 1'b1, 1, 1);
        play(1, 24, -1);
        for (int k = 0; k < 24; k++) begin
            n_cmp++; if (ov[k] !== (k == 10 || k == 20)) begin
                n_bad++; $display("FAIL b2b_valid k=%0d got %b", k, ov[k]);
            end
            n_cmp++; if (oe[k] !== 1'b0) begin
                n_bad++; $display("FAIL b2b_ferr k=%0d got %b want 0", k, oe[k]);
            end
        end
        n_cmp++; if (od[10] !== 8'h3C) begin
            n_bad++; $display("FAIL b2b_data0 got %h want 3c", od[10]);
        end
        n_cmp++; if (od[20] !== 8'hC3) begin
            n_bad++; $display("FAIL b2b_data1 got %h want c3", od[20]);
        end
        $display("back_to_back: 3c,c3 -> %h,%h", od[10], od[20]);
    endtask

    task automatic test_framing_error();
        add_frame(8'h5A, 1'b0, 1, 1);
        add_const(1'b0, 5);
        add_const(1'b1, 1);
        add_frame(8'h11, 1'b1, 1, 1);
        play(1, 30, -1);
        for (int k = 0; k < 30; k++) begin
            n_cmp++; if (oe[k] !== (k == 10)) begin
                n_bad++; $display("FAIL ferr_strobe k=%0d got %b", k, oe[k]);
            end
            n_cmp++; if (ov[k] !== (k == 26)) begin
                n_bad++; $display("FAIL ferr_valid k=%0d got %b", k, ov[k]);
            end
        end
        for (int k = 10; k <= 16; k++) begin
            n_cmp++; if (ob[k] !== (k <= 15)) begin
                n_bad++; $display("FAIL ferr_busy k=%0d got %b want %b", k, ob[k], (k <= 15));
            end
        end
        n_cmp++; if (od[11] !== 8'hC3) begin
            n_bad++; $display("FAIL ferr_data_kept got %h want c3", od[11]);
        end
        n_cmp++; if (od[26] !== 8'h11) begin
            n_bad++; $display("FAIL ferr_next_data got %h want 11", od[26]);
        end
        $display("framing_error: 5a bad stop, then 11 -> %h", od[26]);
    endtask

    task automatic test_glitch();
        add_frame(8'h96, 1'b1, 4, 2);
        add_frame(8'h69, 1'b1, 4, 4);
        play(4, 82, -1);
        for (int k = 0; k < 82; k++) begin
            n_cmp++; if (ov[k] !== (k == 38 || k == 76)) begin
                n_bad++; $display("FAIL cpb4_valid k=%0d got %b", k, ov[k]);
            end
        end
        n_cmp++; if (od[38] !== 8'h96) begin
            n_bad++; $display("FAIL cpb4_data0 got %h want 96", od[38]);
        end
        n_cmp++; if (od[76] !== 8'h69) begin
            n_bad++; $display("FAIL cpb4_data1 got %h want 69", od[76]);
        end
        $display("cpb4: 96 (short stop), 69 -> %h,%h", od[38], od[76]);
        add_const(1'b0, 1);
        play(4, 8, -1);
        n_cmp++; if (ob[1] !== 1'b1) begin
            n_bad++; $display("FAIL glitch_busy1 got %b want 1", ob[1]);
        end
        n_cmp++; if (ob[2] !== 1'b0) begin
            n_bad++; $display("FAIL glitch_busy2 got %b want 0", ob[2]);
        end
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if ({ov[k], oe[k]} !== 2'b00) begin
                n_bad++; $display("FAIL glitch_strobe k=%0d got v=%b fe=%b want 0", k, ov[k], oe[k]);
            end
        end
        n_cmp++; if (od[7] !== 8'h69) begin
            n_bad++; $display("FAIL glitch_data got %h want 69", od[7]);
        end
        $display("glitch: busy %b%b, data %h", ob[1], ob[2], od[7]);
    endtask

    task automatic test_reset_midframe();
        add_const(1'b0, 1);
        line_q.push_back(1'b0); line_q.push_back(1'b1);
        line_q.push_back(1'b0); line_q.push_back(1'b1);
        add_const(1'b1, 2);
        add_frame(8'hFF, 1'b1, 1, 1);
        play(1, 20, 5);
        n_cmp++; if (ob[5] !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_busy_before got %b want 1", ob[5]);
        end
        n_cmp++; if ({od[6], ov[6], oe[6], ob[6]} !== 11'd0) begin
            n_bad++; $display("FAIL rstmid_outputs got data=%h v=%b fe=%b busy=%b want 0", od[6], ov[6], oe[6], ob[6]);
        end
        for (int k = 0; k < 20; k++) begin
            n_cmp++; if ({ov[k], oe[k]} !== {(k == 17), 1'b0}) begin
                n_bad++; $display("FAIL rstmid_strobe k=%0d got v=%b fe=%b", k, ov[k], oe[k]);
            end
        end
        n_cmp++; if (od[17] !== 8'hFF) begin
            n_bad++; $display("FAIL rstmid_data got %h want ff", od[17]);
        end
        $display("reset_midframe: then ff -> %h", od[17]);
    endtask

    task automatic test_loopback();
        logic [7:0] words[4];
        words = '{8'h00, 8'h01, 8'h80, 8'hFF};
        for (int n = 0; n < 4; n++) begin
            add_frame(words[n], 1'b1, 1, 1);
            add_const(1'b1, 1);
        end
        play(1, 48, -1);
        for (int k = 0; k < 48; k++) begin
            n_cmp++; if (ov[k] !== ((k % 11) == 10)) begin
                n_bad++; $display("FAIL loop_valid k=%0d got %b", k, ov[k]);
            end
        end
        for (int n = 0; n < 4; n++) begin
            n_cmp++; if (od[11*n+10] !== words[n]) begin
                n_bad++; $display("FAIL loop_data n=%0d got %h want %h", n, od[11*n+10], words[n]);
            end
            $display("loopback: word %0d sent %h got %h", n, words[n], od[11*n+10]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_framing_error();
        test_glitch();
        test_reset_midframe();
        test_loopback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
